// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 mux channel: grants one requester at a time,
// drives the select and forwards its word downstream in bursts of at most MAX_BURST.
module mux4_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    input  logic                 dout_ready,
    output logic [3:0]           gnt,
    output logic [1:0]           sel,
    output logic [WIDTH-1:0]     dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 fsm_state
);

    // Handshake: a word moves downstream in any cycle where dout_valid && dout_ready;
    // dout_valid follows the granted request, and dout holds while dout_ready is low.

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] ptr;
    logic [3:0] cnt;
    logic [1:0] winner;
    logic       any_req;
    logic       xfer;
    logic       rel;

    // Scan from the farthest offset down so the offset closest to ptr wins.
    always_comb begin
        winner  = ptr;
        any_req = |req;
        for (int k = 3; k >= 0; k--) begin
            if (req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   if (rel)     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == GRANT);
        fsm_state  = state;
        dout       = din[sel*WIDTH +: WIDTH];
        dout_valid = (state == GRANT) && req[sel];
        xfer       = dout_valid && dout_ready;
        rel        = (state == GRANT) && (!req[sel] || (xfer && cnt == LAST_BEAT));
    end

    // Grant bookkeeping; ptr moves only on release so idle cycles never skip anyone.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            gnt <= 4'b0000;
            sel <= 2'd0;
            ptr <= 2'd0;
            cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt <= 4'b0001 << winner;
                        sel <= winner;
                        cnt <= 4'd0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        gnt <= 4'b0000;
                        cnt <= 4'd0;
                        ptr <= sel + 2'd1;
                    end else if (xfer) begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    gnt <= 4'b0000;
                    cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios plus random traffic,
// all checked against an owner/beat-count model of the arbitration rules.
module tb_mux4_rr_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic           clock;
    logic           resetn;
    logic [3:0]     req;
    logic [4*W-1:0] din;
    logic           dout_ready;
    logic [3:0]     gnt;
    logic [1:0]     sel;
    logic [W-1:0]   dout;
    logic           dout_valid;
    logic           busy;
    logic           fsm_state;

    mux4_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .req        (req),
        .din        (din),
        .dout_ready (dout_ready),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]   gnt;
        logic [1:0]   sel;
        logic         busy;
        logic         valid;
        logic [W-1:0] dout;
    } cyc_exp_t;

    cyc_exp_t     cyc_q[$];
    logic [W-1:0] exp_q[$];
    int           obs_grants[$];
    int           checks   = 0;
    int           failures = 0;
    int           xfer_cnt = 0;
    logic [3:0]   prev_gnt = 4'b0000;

    // reference model: who owns the channel, how many beats it has moved, where the scan starts
    int owner    = -1;
    int beats    = 0;
    int ptr_m    = 0;
    int last_sel = 0;
    bit known    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs, predict this cycle's outputs, advance the model
    task automatic cycle(input logic rn, input logic [3:0] r, input logic [4*W-1:0] d, input logic rdy);
        cyc_exp_t e;
        resetn     = rn;
        req        = r;
        din        = d;
        dout_ready = rdy;
        if (known) begin
            e.gnt   = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
            e.sel   = 2'(last_sel);
            e.busy  = (owner >= 0);
            e.valid = (owner >= 0) && r[owner];
            e.dout  = (owner >= 0) ? d[owner*W +: W] : '0;
            cyc_q.push_back(e);
            if (e.valid && rdy) exp_q.push_back(e.dout);
        end
        @(posedge clock);
        if (!rn) begin
            owner = -1; beats = 0; ptr_m = 0; last_sel = 0; known = 1;
        end else if (known) begin
            if (owner < 0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (r[(ptr_m + k) % 4]) owner = (ptr_m + k) % 4;
                end
                if (owner >= 0) begin
                    beats = 0;
                    last_sel = owner;
                end
            end else if (!r[owner]) begin
                ptr_m = (owner + 1) % 4;
                owner = -1;
            end else if (rdy) begin
                beats++;
                if (beats == MB) begin
                    ptr_m = (owner + 1) % 4;
                    owner = -1;
                end
            end
        end
        #1;
    endtask

    function automatic logic [4*W-1:0] rand_din();
        logic [4*W-1:0] v;
        for (int i = 0; i < 4; i++) v[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    task automatic check_grants(input string nm, input int n, input logic [15:0] exp);
        chk({nm, "_count"}, 32'(obs_grants.size()), 32'(n));
        for (int i = 0; i < n && i < obs_grants.size(); i++)
            chk({nm, "_order"}, 32'(obs_grants[i]), 32'(exp[2*i +: 2]));
    endtask

    task automatic do_reset(input logic [3:0] r);
        cycle(1'b0, r, rand_din(), 1'b1);
        cycle(1'b0, r, rand_din(), 1'b1);
        obs_grants.delete();
        xfer_cnt = 0;
    endtask

    // scoreboard monitor, sampling on the falling edge
    always @(negedge clock) begin
        cyc_exp_t e;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            chk("gnt", 32'(gnt), 32'(e.gnt));
            chk("sel", 32'(sel), 32'(e.sel));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("fsm_state", 32'(fsm_state), 32'(e.busy));
            chk("dout_valid", 32'(dout_valid), 32'(e.valid));
            if (e.valid) chk("dout", 32'(dout), 32'(e.dout));
        end
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            xfer_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL xfer_unexpected actual=%0h required=none time=%0t", dout, $time);
            end else begin
                chk("xfer_data", 32'(dout), 32'(exp_q.pop_front()));
            end
        end
        if (gnt !== 4'b0000 && prev_gnt === 4'b0000) obs_grants.push_back(int'(sel));
        prev_gnt = gnt;
    end

    initial begin
        logic [4*W-1:0] d;
        logic [3:0]     r;
        resetn = 1'b0; req = 4'b0; din = '0; dout_ready = 1'b0;

        // reset with everyone requesting, then first grant goes to 0
        do_reset(4'b1111);
        cycle(1'b1, 4'b1111, rand_din(), 1'b1);
        cycle(1'b1, 4'b1111, rand_din(), 1'b1);
        check_grants("reset_first_grant", 1, 16'h0000);

        // single requester burst with re-grant after the bubble
        do_reset(4'b0000);
        d = rand_din();
        d[2*W +: W] = 8'hA5;
        for (int i = 0; i < 8; i++) cycle(1'b1, 4'b0100, d, 1'b1);
        check_grants("single_burst", 2, 16'h000A);

        // round-robin with everyone requesting
        do_reset(4'b0000);
        for (int i = 0; i < 23; i++) cycle(1'b1, 4'b1111, rand_din(), 1'b1);
        check_grants("round_robin", 5, {6'b0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        chk("round_robin_xfers", 32'(xfer_cnt), 32'd18);

        // backpressure on requester 1, din held so dout must stay put during stalls
        do_reset(4'b0000);
        d = rand_din();
        cycle(1'b1, 4'b0010, d, 1'b0);
        xfer_cnt = 0;
        for (int i = 0; i < 6; i++) cycle(1'b1, 4'b0010, d, (i == 1 || i == 2) ? 1'b0 : 1'b1);
        chk("backpressure_xfers", 32'(xfer_cnt), 32'd4);
        cycle(1'b1, 4'b0000, d, 1'b1);

        // early drop by requester 3, pointer wraps to 0
        do_reset(4'b0000);
        cycle(1'b1, 4'b1000, rand_din(), 1'b1);
        cycle(1'b1, 4'b1000, rand_din(), 1'b1);
        cycle(1'b1, 4'b1000, rand_din(), 1'b1);
        cycle(1'b1, 4'b0001, rand_din(), 1'b1);
        cycle(1'b1, 4'b1001, rand_din(), 1'b1);
        cycle(1'b1, 4'b1001, rand_din(), 1'b1);
        check_grants("early_drop_wrap", 2, 16'h0003);

        // reset in the middle of a burst
        do_reset(4'b0000);
        cycle(1'b1, 4'b0100, rand_din(), 1'b1);
        cycle(1'b1, 4'b0100, rand_din(), 1'b1);
        cycle(1'b1, 4'b0100, rand_din(), 1'b1);
        cycle(1'b0, 4'b0100, rand_din(), 1'b1);
        obs_grants.delete();
        cycle(1'b1, 4'b0110, rand_din(), 1'b1);
        cycle(1'b1, 4'b0110, rand_din(), 1'b1);
        check_grants("reset_mid_burst", 1, 16'h0001);

        // random traffic with sticky requests and rare resets
        r = 4'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1, r, rand_din(),
                  ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
        end
        cycle(1'b1, 4'b0000, rand_din(), 1'b1);
        @(negedge clock);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
